// File: rtl/coherence_bus_arbiter_if.sv
// Bus between the two cpus and the coherence arbiter: per-cpu requests and tags
// in, grant / snoop / invalidate / data-source steering out.
interface coherence_bus_arbiter_if #(
    parameter int unsigned TAG_W = 13
);
    logic [1:0]       read_miss;
    logic [1:0]       write_miss;
    logic [1:0]       invalidate;
    logic [TAG_W-1:0] bico0;
    logic [TAG_W-1:0] bico1;
    logic [1:0]       cpu_search_found;
    logic             u_rdy;
    logic [1:0]       grant;
    logic [TAG_W-1:0] boci;
    logic [1:0]       cpu_search;
    logic [1:0]       cpu_datasel0;
    logic [1:0]       cpu_datasel1;
    logic [1:0]       invalidate_from_other_cpu;
    logic             mem_req;
    logic             timeout_err;
    logic             busy;

    // Arbiter side.
    modport master (
        input  read_miss, write_miss, invalidate, bico0, bico1, cpu_search_found, u_rdy,
        output grant, boci, cpu_search, cpu_datasel0, cpu_datasel1,
        output invalidate_from_other_cpu, mem_req, timeout_err, busy
    );

    // Cpu / memory side.
    modport slave (
        output read_miss, write_miss, invalidate, bico0, bico1, cpu_search_found, u_rdy,
        input  grant, boci, cpu_search, cpu_datasel0, cpu_datasel1,
        input  invalidate_from_other_cpu, mem_req, timeout_err, busy
    );
endinterface

// File: rtl/coherence_bus_arbiter.sv
// Snooping-bus arbiter for two cpus: round-robin pick of one requester, snoop the
// peer, then source the line from the peer cache or from unified memory.
// All outputs are registered; they are computed from the next state.
module coherence_bus_arbiter #(
    parameter int unsigned TAG_W   = 13,
    parameter int unsigned TIMEOUT = 255
) (
    input logic                     clk,
    input logic                     rst_n,
    coherence_bus_arbiter_if.master bus_io
);
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] SelNone = 2'b00;
    localparam logic [1:0] SelMem  = 2'b01;
    localparam logic [1:0] SelPeer = 2'b10;

    typedef enum logic [2:0] {StIdle, StSnoop, StDecide, StMem, StDone} state_e;
    typedef enum logic [1:0] {TxInv, TxRead, TxWrite} tx_e;

    state_e           state_q, state_d;
    tx_e              tx_q, tx_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic [TAG_W-1:0] boci_q, boci_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic [1:0] grant_q, grant_d;
    logic [1:0] search_q, search_d;
    logic [1:0] inv_q, inv_d;
    logic [1:0] sel0_q, sel0_d;
    logic [1:0] sel1_q, sel1_d;
    logic       mem_req_q, mem_req_d;
    logic       tmo_q, tmo_d;
    logic       busy_q, busy_d;

    logic [1:0] req;
    logic       peer;
    logic       new_owner;
    logic       finish;
    logic       abort;
    logic [1:0] sel;

    assign req  = bus_io.read_miss | bus_io.write_miss | bus_io.invalidate;
    assign peer = ~owner_q;

    // Next-state, transaction latching and next values of the registered outputs.
    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        owner_d   = owner_q;
        last_d    = last_q;
        boci_d    = boci_q;
        cnt_d     = cnt_q;
        grant_d   = '0;
        search_d  = '0;
        inv_d     = '0;
        sel0_d    = SelNone;
        sel1_d    = SelNone;
        mem_req_d = 1'b0;
        tmo_d     = 1'b0;
        new_owner = owner_q;
        finish    = 1'b0;
        abort     = 1'b0;
        sel       = SelNone;

        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    // Tie goes to whichever cpu was not served last.
                    new_owner = (&req) ? ~last_q : req[1];
                    owner_d   = new_owner;
                    if (bus_io.write_miss[new_owner]) begin
                        tx_d = TxWrite;
                    end else if (bus_io.read_miss[new_owner]) begin
                        tx_d = TxRead;
                    end else begin
                        tx_d = TxInv;
                    end
                    boci_d              = new_owner ? bus_io.bico1 : bus_io.bico0;
                    search_d[~new_owner] = 1'b1;
                    state_d             = StSnoop;
                end
            end
            StSnoop: begin
                // Writes and upgrades both kill the peer's copy.
                if (tx_q != TxRead) begin
                    inv_d[peer] = 1'b1;
                end
                state_d = StDecide;
            end
            StDecide: begin
                if (tx_q == TxInv) begin
                    finish = 1'b1;
                end else if (bus_io.cpu_search_found[peer]) begin
                    finish = 1'b1;
                    sel    = SelPeer;
                end else begin
                    state_d   = StMem;
                    mem_req_d = 1'b1;
                end
            end
            StMem: begin
                cnt_d = cnt_q + CntW'(1);
                // A ready in the final allowed cycle still wins over the abort.
                if (bus_io.u_rdy) begin
                    finish = 1'b1;
                    sel    = SelMem;
                end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    finish = 1'b1;
                    abort  = 1'b1;
                end else begin
                    mem_req_d = 1'b1;
                end
            end
            StDone: begin
                last_d  = owner_q;
                cnt_d   = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (finish) begin
            state_d = StDone;
            if (abort) begin
                tmo_d = 1'b1;
            end else begin
                grant_d[owner_q] = 1'b1;
                if (owner_q) begin
                    sel1_d = sel;
                end else begin
                    sel0_d = sel;
                end
            end
        end

        busy_d = (state_d != StIdle);
    end

    // State, transaction context and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            tx_q      <= TxInv;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            boci_q    <= '0;
            cnt_q     <= '0;
            grant_q   <= '0;
            search_q  <= '0;
            inv_q     <= '0;
            sel0_q    <= SelNone;
            sel1_q    <= SelNone;
            mem_req_q <= 1'b0;
            tmo_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            boci_q    <= boci_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            search_q  <= search_d;
            inv_q     <= inv_d;
            sel0_q    <= sel0_d;
            sel1_q    <= sel1_d;
            mem_req_q <= mem_req_d;
            tmo_q     <= tmo_d;
            busy_q    <= busy_d;
        end
    end

    assign bus_io.grant                     = grant_q;
    assign bus_io.boci                      = boci_q;
    assign bus_io.cpu_search                = search_q;
    assign bus_io.cpu_datasel0              = sel0_q;
    assign bus_io.cpu_datasel1              = sel1_q;
    assign bus_io.invalidate_from_other_cpu = inv_q;
    assign bus_io.mem_req                   = mem_req_q;
    assign bus_io.timeout_err               = tmo_q;
    assign bus_io.busy                      = busy_q;
endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// Bench for coherence_bus_arbiter: directed and random request rounds; a
// reference model predicts each transaction's outcome into a queue, and a
// monitor checks every grant / timeout against the head of that queue.
module tb_coherence_bus_arbiter;
    localparam int unsigned TAG_W   = 13;
    localparam int unsigned TIMEOUT = 255;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    coherence_bus_arbiter_if #(.TAG_W(TAG_W)) bus ();

    coherence_bus_arbiter #(
        .TAG_W  (TAG_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus_io(bus)
    );

    typedef struct {
        logic [1:0]       grant;
        logic [1:0]       sel0;
        logic [1:0]       sel1;
        logic [TAG_W-1:0] boci;
        logic             tmo;
        int               lat;     // cycles from first busy cycle to completion
        int               mem;     // cycles with mem_req high
        logic [1:0]       search;
        logic [1:0]       inv;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   last_owner = 1;
    int   mem_delay = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Outcome of one transaction owned by cpu o, straight from the protocol rules.
    function automatic exp_t model(input int o, input logic [1:0] rm, input logic [1:0] wm,
                                   input logic [TAG_W-1:0] tag, input logic [1:0] found,
                                   input int delay);
        exp_t       e;
        int         p;
        int         typ;  // 2 write, 1 read, 0 invalidate
        logic [1:0] s;
        p   = 1 - o;
        typ = wm[o] ? 2 : (rm[o] ? 1 : 0);
        e.boci   = tag;
        e.tmo    = 1'b0;
        e.mem    = 0;
        e.search = (p == 1) ? 2'b10 : 2'b01;
        e.inv    = (typ == 1) ? 2'b00 : e.search;
        s        = 2'b00;
        if (typ == 0) begin
            e.lat = 2;
        end else if (found[p]) begin
            s     = 2'b10;
            e.lat = 2;
        end else if (delay < int'(TIMEOUT)) begin
            s     = 2'b01;
            e.mem = delay + 1;
            e.lat = 3 + delay;
        end else begin
            e.tmo = 1'b1;
            e.mem = TIMEOUT;
            e.lat = 2 + TIMEOUT;
        end
        e.grant = e.tmo ? 2'b00 : ((o == 1) ? 2'b10 : 2'b01);
        e.sel0  = (!e.tmo && o == 0) ? s : 2'b00;
        e.sel1  = (!e.tmo && o == 1) ? s : 2'b00;
        return e;
    endfunction

    // Unified memory: ready in MEM cycle number mem_delay (0-based).
    int mcnt = 0;
    always @(negedge clk) begin
        if (bus.mem_req) begin
            bus.u_rdy = (mcnt == mem_delay);
            mcnt++;
        end else begin
            bus.u_rdy = 1'b0;
            mcnt = 0;
        end
    end

    // Monitor: track per-transaction activity, check on each completion.
    int         cyc = 0;
    int         mem_seen = 0;
    logic [1:0] srch_seen = 2'b00;
    logic [1:0] inv_seen = 2'b00;
    logic       busy_prev = 1'b0;
    logic       chk_idle = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            cyc = 0; mem_seen = 0; srch_seen = 2'b00; inv_seen = 2'b00;
            busy_prev = 1'b0; chk_idle = 1'b0;
        end else begin
            if (chk_idle) begin
                chk("busy_after_done", 32'(bus.busy), 32'd0);
                chk_idle = 1'b0;
            end
            if (bus.busy && !busy_prev) cyc = 0;
            else if (bus.busy) cyc++;
            busy_prev = bus.busy;
            if (bus.mem_req) mem_seen++;
            srch_seen = srch_seen | bus.cpu_search;
            inv_seen  = inv_seen | bus.invalidate_from_other_cpu;
            if (bus.grant != 2'b00 || bus.timeout_err) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_completion: got grant %b timeout_err %b, none expected",
                             bus.grant, bus.timeout_err);
                end else begin
                    e = exp_q.pop_front();
                    chk("grant", 32'(bus.grant), 32'(e.grant));
                    chk("timeout_err", 32'(bus.timeout_err), 32'(e.tmo));
                    chk("datasel0", 32'(bus.cpu_datasel0), 32'(e.sel0));
                    chk("datasel1", 32'(bus.cpu_datasel1), 32'(e.sel1));
                    chk("boci", 32'(bus.boci), 32'(e.boci));
                    chk("latency", 32'(cyc), 32'(e.lat));
                    chk("mem_req_cycles", 32'(mem_seen), 32'(e.mem));
                    chk("cpu_search", 32'(srch_seen), 32'(e.search));
                    chk("invalidate_other", 32'(inv_seen), 32'(e.inv));
                end
                mem_seen = 0; srch_seen = 2'b00; inv_seen = 2'b00;
                chk_idle = 1'b1;
            end
        end
    end

    task automatic clear_reqs();
        bus.read_miss  = 2'b00;
        bus.write_miss = 2'b00;
        bus.invalidate = 2'b00;
    endtask

    task automatic check_all_zero(input string name);
        chk(name, {bus.grant, bus.boci, bus.cpu_search, bus.cpu_datasel0, bus.cpu_datasel1,
                   bus.invalidate_from_other_cpu, bus.mem_req, bus.timeout_err, bus.busy}, 32'd0);
    endtask

    // One round: raise the given requests, predict the service order, and drop
    // each cpu's request once its transaction completes. Called at a negedge.
    task automatic do_round(input logic [1:0] rm, input logic [1:0] wm, input logic [1:0] iv,
                            input logic [TAG_W-1:0] t0, input logic [TAG_W-1:0] t1,
                            input logic [1:0] found, input int delay);
        logic [1:0] req;
        int         order[$];
        int         budget;
        int         o;
        req = rm | wm | iv;
        if (req == 2'b11) begin
            order.push_back(1 - last_owner);
            order.push_back(last_owner);
        end else if (req[0]) begin
            order.push_back(0);
        end else if (req[1]) begin
            order.push_back(1);
        end
        foreach (order[k]) exp_q.push_back(model(order[k], rm, wm, (order[k] == 1) ? t1 : t0,
                                                 found, delay));
        if (order.size() > 0) last_owner = order[order.size() - 1];
        bus.read_miss        = rm;
        bus.write_miss       = wm;
        bus.invalidate       = iv;
        bus.bico0            = t0;
        bus.bico1            = t1;
        bus.cpu_search_found = found;
        mem_delay            = delay;
        foreach (order[k]) begin
            o      = order[k];
            budget = 0;
            do begin
                @(negedge clk);
                budget++;
            end while (!(bus.grant != 2'b00 || bus.timeout_err) && budget < 400);
            if (budget >= 400) begin
                n_cmp++;
                n_bad++;
                $display("FAIL completion_wait: got no grant/timeout in 400 cycles, required one");
                rst_n = 1'b0;
                clear_reqs();
                exp_q.delete();
                last_owner = 1;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            bus.read_miss[o]  = 1'b0;
            bus.write_miss[o] = 1'b0;
            bus.invalidate[o] = 1'b0;
        end
    endtask

    initial begin
        int budget;
        clear_reqs();
        bus.bico0            = '0;
        bus.bico1            = '0;
        bus.cpu_search_found = 2'b00;
        repeat (2) @(negedge clk);
        check_all_zero("reset_outputs");
        rst_n = 1'b1;
        @(negedge clk);

        // cpu0 read, peer hit.
        do_round(2'b01, 2'b00, 2'b00, 13'h0A5, 13'h000, 2'b10, 0);
        // cpu1 write, peer miss, memory ready in 4th MEM cycle.
        do_round(2'b00, 2'b10, 2'b00, 13'h000, 13'h1F0, 2'b00, 3);
        // Both read together: cpu0 first.
        do_round(2'b11, 2'b00, 2'b00, 13'h011, 13'h022, 2'b11, 1);
        // cpu0 invalidate only.
        do_round(2'b00, 2'b00, 2'b01, 13'h033, 13'h000, 2'b00, 0);
        // Both again after cpu0 was last served: cpu1 first.
        do_round(2'b11, 2'b00, 2'b00, 13'h044, 13'h055, 2'b00, 0);
        // Memory never ready: abort after TIMEOUT MEM cycles.
        do_round(2'b01, 2'b00, 2'b00, 13'h066, 13'h000, 2'b00, 1000);

        // Reset while waiting on memory.
        bus.read_miss        = 2'b10;
        bus.bico1            = 13'h0777;
        bus.cpu_search_found = 2'b00;
        mem_delay            = 1000;
        budget               = 0;
        while (!bus.mem_req && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        repeat (3) @(negedge clk);
        chk("mem_req_before_reset", 32'(bus.mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid_mem");
        clear_reqs();
        exp_q.delete();
        last_owner = 1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_round(2'b11, 2'b00, 2'b00, 13'h0123, 13'h0456, 2'b11, 0);

        // Random rounds: mixed request types per cpu, hits, fills, rare aborts.
        for (int r = 0; r < 40; r++) begin
            logic [1:0] rm, wm, iv, rq, fnd;
            int         m, d;
            rm = 2'b00; wm = 2'b00; iv = 2'b00;
            rq = 2'($urandom_range(1, 3));
            for (int i = 0; i < 2; i++) begin
                if (rq[i]) begin
                    m = $urandom_range(1, 7);
                    wm[i] = m[2];
                    rm[i] = m[1];
                    iv[i] = m[0];
                end
            end
            fnd = 2'($urandom_range(0, 3));
            d   = ($urandom_range(0, 19) == 0) ? 300 : $urandom_range(0, 6);
            do_round(rm, wm, iv, 13'($urandom), 13'($urandom), fnd, d);
        end

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL leftover_expected: got %0d pending entries, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test, required finish before time limit");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/coherence_bus_arbiter.md
Name: coherence_bus_arbiter

Overview:
- Snooping-bus arbiter and coherence sequencer for two cpu instances.
- Sits directly downstream of each cpu's miss/invalidate outputs and drives those cpus' grant, BOCI, search, datasel and invalidate inputs.
- Serialises one coherence transaction at a time using round-robin fairness.
- For each transaction, decides whether the line is sourced from the peer cache or from unified memory.

Parameters:
- TAG_W, 13, width of the BICO/BOCI tag bus.
- TIMEOUT, 255, maximum cycles spent in MEM before the transaction is aborted.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- read_miss  input  2  per-cpu read miss request, bit i = cpu i, level
- write_miss  input  2  per-cpu write miss request, level
- invalidate  input  2  per-cpu invalidate (upgrade) request, level
- BICO0, BICO1  input  TAG_W  each  tag from cpu0 / cpu1
- cpu_search_found  input  2  peer cache hit response, bit i from cpu i
- u_rdy  input  1  unified memory operation finished
- grant  output  2  one-cycle transaction-complete pulse to the requester
- BOCI  output  TAG_W  broadcast tag of the active transaction
- cpu_search  output  2  snoop request to the peer cpu
- cpu_datasel0, cpu_datasel1  output  2  each  data source: 00 none, 01 unified memory, 10 other processor
- invalidate_from_other_cpu  output  2  invalidate pulse to the peer cpu
- mem_req  output  1  high while waiting on unified memory
- timeout_err  output  1  one-cycle pulse on abort
- busy  output  1  FSM not in IDLE

Behaviour:
- Reset is asynchronous.
  - State goes to IDLE; last_owner = 1, so cpu0 wins the first tie.
  - All outputs are 0; BOCI = 0; timeout counter = 0.
  - Reset asserted mid-transaction aborts it without a grant.
- Request for cpu i = read_miss[i] | write_miss[i] | invalidate[i].
- Type priority within one cpu: write_miss > read_miss > invalidate.
- IDLE:
  - With any request, choose an owner and go to SNOOP.
  - If both cpus request, the owner is the cpu that is not last_owner.
  - On transition, latch owner, type and the owner's BICO into BOCI. BOCI holds until the next transaction.
  - Request changes after latching are ignored until DONE.
- SNOOP (1 cycle): cpu_search[peer] = 1. Next state is DECIDE.
- DECIDE (1 cycle): sample cpu_search_found[peer].
  - invalidate type: invalidate_from_other_cpu[peer] = 1. Next state DONE, datasel 00.
  - write_miss type: invalidate_from_other_cpu[peer] = 1.
    - If found: DONE with datasel 10.
    - Else: MEM.
  - read_miss type:
    - If found: DONE with datasel 10.
    - Else: MEM.
- MEM:
  - mem_req = 1 and the timeout counter increments each cycle.
  - u_rdy sampled high → DONE with datasel 01. A u_rdy already high in the first MEM cycle counts.
  - Counter reaching TIMEOUT → DONE with datasel 00, timeout_err pulse, no grant.
- DONE (1 cycle):
  - grant[owner] = 1 and cpu_datasel(owner) = the selected value. The non-owner's datasel stays 00.
  - Update last_owner = owner and clear the counter. Next state IDLE.
  - A request may be accepted again on the next cycle.
- Latency from the request-accept cycle N:
  - Grant at N+3 for a snoop hit or invalidate.
  - Grant at N+4+k for a memory fill, where k = the number of MEM cycles before u_rdy.
- The peer's own outstanding request waits in IDLE arbitration. It is never dropped. Starvation-free by round robin.
- Outputs invalidate_from_other_cpu, grant and timeout_err are registered single-cycle pulses. cpu_search and mem_req are level during their state.
- Only one bit of grant, cpu_search or invalidate_from_other_cpu is ever set at a time.

Test Plan:
- cpu0 read_miss, BICO0=13'h0A5, cpu1 search_found=1 → cpu_search=2'b10 in SNOOP, BOCI=0A5, grant=2'b01 with cpu_datasel0=10 exactly 3 cycles after accept.
- cpu1 write_miss, BICO1=13'h1F0, peer not found, u_rdy after 4 cycles → invalidate_from_other_cpu=2'b01 in DECIDE, mem_req high 4 cycles, grant=2'b10 with cpu_datasel1=01.
- Both cpus request read_miss in the same cycle after reset → cpu0 is served first, then cpu1 without re-arbitration loss. Repeat both requesting → cpu1 first (alternation).
- cpu0 invalidate only → invalidate_from_other_cpu=2'b10, grant=2'b01, cpu_datasel0=00, mem_req never asserted.
- Read miss, peer not found, u_rdy never asserted → after 255 MEM cycles timeout_err pulse, grant stays 0, busy drops the next cycle.
- rst_n low during MEM → all outputs 0 immediately. After release, a fresh request completes normally with cpu0 priority.
